// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: frame constants and FSM states.
package uart_tx_fifo_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock byte FIFO with occupancy count; pointers wrap naturally since DEPTH is a power of 2.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array is written on accepted pushes only and needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and count; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a shifter paced by a fractional baud accumulator.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int CLK_FREQUENCY = 100_000_000,
    parameter  int BAUD          = 12_000_000,
    parameter  int FIFO_DEPTH    = 16,
    localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          txd,
    output logic          busy,
    output logic [CW-1:0] fifo_count
);

    localparam int ACC_W = $clog2(CLK_FREQUENCY + BAUD);
    localparam int SUM_W = ACC_W + 1;

    tx_state_e  state;
    tx_state_e  state_next;
    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] acc_sum;
    logic       tick;
    logic [7:0] shifter;
    logic [2:0] bit_cnt;
    logic       txd_next;
    logic       load;
    logic       shift;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;

    assign tx_ready = ~fifo_full;
    assign busy     = (state != ST_IDLE) | (fifo_count != '0);
    assign acc_sum  = {1'b0, acc} + SUM_W'(BAUD);
    assign tick     = (state != ST_IDLE) && (acc_sum >= SUM_W'(CLK_FREQUENCY));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_valid & tx_ready),
        .wdata   (tx_data),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Frame sequencing: choose next state, line level, and when to pop/load/shift.
    always_comb begin
        state_next = state;
        txd_next   = UART_STOP_BIT;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load       = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                txd_next = UART_START_BIT;
                if (tick) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_next = shifter[0];
                if (tick) begin
                    shift = 1'b1;
                    if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load       = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus registered line output so txd never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            txd   <= UART_STOP_BIT;
        end else begin
            state <= state_next;
            txd   <= txd_next;
        end
    end

    // Fractional baud accumulator, restarted at every frame so each frame starts on a clean phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= '0;
        end else if (state != ST_IDLE) begin
            if (tick) begin
                acc <= ACC_W'(acc_sum - SUM_W'(CLK_FREQUENCY));
            end else begin
                acc <= ACC_W'(acc_sum);
            end
        end
    end

    // Data shifter (LSB first) and count of data bits already sent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shifter <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shifter <= fifo_rdata;
            bit_cnt <= '0;
        end else if (shift) begin
            shifter <= {1'b0, shifter[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed sequence plus random bytes, checked by a line-level UART model.
module tb_uart_tx_fifo;

    localparam int CLK_F     = 100_000_000;
    localparam int BAUD_R    = 12_000_000;
    localparam int DEPTH     = 16;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int FRAME_LEN = (10 * CLK_F + BAUD_R - 1) / BAUD_R;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          txd;
    logic          busy;
    logic [CW-1:0] fifo_count;

    logic [7:0]    s_tx_data;
    logic          s_tx_valid;
    logic          s_tx_ready;
    logic          s_txd;
    logic          s_busy;
    logic [CW-1:0] s_fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    bit  in_frame = 1'b0;
    int  pos = 0;
    int  frames_done = 0;
    int  back_to_back = 0;
    int  last_end_cyc = -10;
    logic [9:0] frame_bits;

    int stall_cycles = 0;
    int cnt_at_stall = 0;

    uart_tx_fifo #(
        .CLK_FREQUENCY (CLK_F),
        .BAUD          (BAUD_R),
        .FIFO_DEPTH    (DEPTH)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(
        .CLK_FREQUENCY (16),
        .BAUD          (1),
        .FIFO_DEPTH    (DEPTH)
    ) u_slow (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (s_tx_data),
        .tx_valid   (s_tx_valid),
        .tx_ready   (s_tx_ready),
        .txd        (s_txd),
        .busy       (s_busy),
        .fifo_count (s_fifo_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to time events relative to a push.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Push one byte, holding tx_valid until accepted; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] b);
        int budget = 2000;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && budget > 0) begin
            stall_cycles++;
            cnt_at_stall = int'(fifo_count);
            checkOutput("ready_low_count", 32'(fifo_count), 32'(DEPTH));
            @(negedge clk);
            budget--;
        end
        checkOutput("push_accept_timeout", 32'(budget > 0), 32'(1));
        checkOutput("ready_high_count", 32'(int'(fifo_count) < DEPTH), 32'(1));
        exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic waitDrain(input string tag);
        int budget = 20000;
        while ((busy !== 1'b0 || in_frame || exp_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, 32'(budget > 0), 32'(1));
        checkOutput({tag, "_count"}, 32'(fifo_count), 32'(0));
        checkOutput({tag, "_txd"}, 32'(txd), 32'(1));
    endtask

    // Reference receiver: bit k of a frame covers cycles p with floor((p-1)*BAUD/CLK) == k.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_frame = 1'b0;
                pos      = 0;
            end else begin
                if (!in_frame && txd === 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 1;
                    if (cyc == last_end_cyc + 1) back_to_back++;
                    checkOutput("frame_queued", 32'(exp_q.size() != 0), 32'(1));
                    frame_bits = {1'b1, (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00, 1'b0};
                end
                if (in_frame) begin
                    int k;
                    k = int'((longint'(pos - 1) * BAUD_R) / CLK_F);
                    checkOutput("txd_bit", 32'(txd), 32'(frame_bits[k]));
                    if (pos == FRAME_LEN) begin
                        in_frame = 1'b0;
                        frames_done++;
                        last_end_cyc = cyc;
                    end else begin
                        pos++;
                    end
                end
            end
        end
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int base_b2b;
        int t_push;
        logic [9:0] s_bits;
        logic [7:0] b;

        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        s_tx_valid = 1'b0;
        s_tx_data  = 8'h00;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("rst_txd", 32'(txd), 32'(1));
        checkOutput("rst_ready", 32'(tx_ready), 32'(1));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_count", 32'(fifo_count), 32'(0));
        checkOutput("rst_slow_txd", 32'(s_txd), 32'(1));
        reset_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5 at default rates: latency of two edges, then the model checks each bit.
        $display("[TB] single byte 0xA5");
        base = frames_done;
        applyStimulus(8'hA5);
        tx_valid = 1'b0;
        checkOutput("a5_lat_n", 32'(txd), 32'(1));
        checkOutput("a5_busy", 32'(busy), 32'(1));
        @(negedge clk);
        checkOutput("a5_lat_n1", 32'(txd), 32'(1));
        @(negedge clk);
        checkOutput("a5_lat_fall", 32'(txd), 32'(0));
        waitDrain("a5_drain");
        checkOutput("a5_frames", 32'(frames_done - base), 32'(1));

        // Integer ratio 16: every bit exactly 16 clocks.
        $display("[TB] slow instance 0x3C");
        s_bits = {1'b1, 8'h3C, 1'b0};
        checkOutput("slow_ready", 32'(s_tx_ready), 32'(1));
        s_tx_data  = 8'h3C;
        s_tx_valid = 1'b1;
        @(negedge clk);
        s_tx_valid = 1'b0;
        checkOutput("slow_lat_n", 32'(s_txd), 32'(1));
        @(negedge clk);
        checkOutput("slow_lat_n1", 32'(s_txd), 32'(1));
        for (int p = 1; p <= 160; p++) begin
            @(negedge clk);
            checkOutput("slow_bit", 32'(s_txd), 32'(s_bits[(p - 1) / 16]));
        end
        @(negedge clk);
        checkOutput("slow_idle_txd", 32'(s_txd), 32'(1));
        checkOutput("slow_idle_busy", 32'(s_busy), 32'(0));

        // Back-pressure: 20 bytes with tx_valid held high.
        $display("[TB] stream 20 bytes");
        base         = frames_done;
        base_b2b     = back_to_back;
        stall_cycles = 0;
        cnt_at_stall = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'(i));
        end
        tx_valid = 1'b0;
        checkOutput("stream_stalled", 32'(stall_cycles > 0), 32'(1));
        checkOutput("stream_full_count", 32'(cnt_at_stall), 32'(DEPTH));
        waitDrain("stream_drain");
        checkOutput("stream_frames", 32'(frames_done - base), 32'(20));
        checkOutput("stream_no_gap", 32'(back_to_back - base_b2b), 32'(19));

        // Push in the same edge as a pop with five bytes queued.
        $display("[TB] push during pop");
        base = frames_done;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'($urandom));
            if (i == 0) t_push = cyc;
        end
        tx_valid = 1'b0;
        while (cyc != t_push + FRAME_LEN) @(negedge clk);
        checkOutput("pp_count_before", 32'(fifo_count), 32'(5));
        checkOutput("pp_ready", 32'(tx_ready), 32'(1));
        b        = 8'($urandom);
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("pp_count_after", 32'(fifo_count), 32'(5));
        waitDrain("pp_drain");
        checkOutput("pp_frames", 32'(frames_done - base), 32'(7));

        // Reset in the middle of 0x55 with three bytes queued, then one clean frame.
        $display("[TB] reset mid-frame");
        applyStimulus(8'h55);
        t_push = cyc;
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));
        tx_valid = 1'b0;
        while (cyc != t_push + 41) @(negedge clk);
        checkOutput("mid_busy", 32'(busy), 32'(1));
        checkOutput("mid_count", 32'(fifo_count), 32'(3));
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("mid_rst_txd", 32'(txd), 32'(1));
        checkOutput("mid_rst_count", 32'(fifo_count), 32'(0));
        checkOutput("mid_rst_ready", 32'(tx_ready), 32'(1));
        checkOutput("mid_rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        base = frames_done;
        applyStimulus(8'h81);
        tx_valid = 1'b0;
        waitDrain("post_rst_drain");
        checkOutput("post_rst_frames", 32'(frames_done - base), 32'(1));

        // Random bytes with random gaps, including gaps long enough to let the line go idle.
        $display("[TB] random traffic");
        base = frames_done;
        for (int i = 0; i < 24; i++) begin
            int gap;
            applyStimulus(8'($urandom));
            tx_valid = 1'b0;
            gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(80, 200)) : int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
        end
        waitDrain("rand_drain");
        checkOutput("rand_frames", 32'(frames_done - base), 32'(24));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
